// File: rtl/dcmctrl_spi_master.sv
// SPI mode-0 initiator for the dcmctrl register port: one command becomes one
// chip-select-framed burst made of a header byte {write, addr} followed by data bytes.
module dcmctrl_spi_master #(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 8,
    parameter int CS_SETUP   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_write,
    input  logic [6:0] i_cmd_addr,
    input  logic [4:0] i_cmd_len,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy,
    output logic       o_spi_ss,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD
    } state_t;

    localparam logic [15:0] DIV_LD = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] CS_LD  = 16'(CS_SETUP - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_div;
    logic [2:0]  r_bit;
    logic [4:0]  r_left;
    logic        r_write;
    logic [6:0]  r_addr;
    logic        r_header;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_ss;
    logic        r_sclk;
    logic        r_mosi;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;

    logic        w_div_zero;
    logic        w_load_go;
    logic        w_byte_done;
    logic [7:0]  w_load_byte;

    assign w_div_zero  = (r_div == 16'd0);
    // A write data byte may stall LOAD indefinitely; header and read bytes never do.
    assign w_load_go   = (r_state == ST_LOAD) && (r_header || !r_write || i_wr_valid);
    assign w_byte_done = (r_state == ST_SHIFT) && w_div_zero && r_sclk && (r_bit == 3'd7);
    assign w_load_byte = r_header ? {r_write, r_addr} : (r_write ? i_wr_data : 8'h00);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_cmd_ready = (r_state == ST_IDLE);
        o_busy      = (r_state != ST_IDLE);
        o_wr_ready  = w_load_go && !r_header && r_write;
        case (r_state)
            ST_IDLE:  if (i_cmd_valid) w_next = ST_SETUP;
            ST_SETUP: if (w_div_zero) w_next = ST_LOAD;
            ST_LOAD:  if (w_load_go) w_next = ST_SHIFT;
            ST_SHIFT: if (w_byte_done) w_next = (r_left == 5'd0) ? ST_HOLD : ST_GAP;
            ST_GAP:   if (w_div_zero) w_next = ST_LOAD;
            ST_HOLD:  if (w_div_zero) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div      <= 16'd0;
            r_bit      <= 3'd0;
            r_left     <= 5'd0;
            r_write    <= 1'b0;
            r_addr     <= 7'd0;
            r_header   <= 1'b0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_ss       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_write  <= i_cmd_write;
                        r_addr   <= i_cmd_addr;
                        r_left   <= i_cmd_len;
                        r_header <= 1'b1;
                        r_ss     <= 1'b0;
                        r_div    <= CS_LD;
                    end
                end
                ST_SETUP, ST_GAP: begin
                    if (!w_div_zero) r_div <= r_div - 16'd1;
                end
                ST_HOLD: begin
                    if (!w_div_zero) r_div <= r_div - 16'd1;
                    else             r_ss  <= 1'b1;
                end
                ST_LOAD: begin
                    if (w_load_go) begin
                        r_tx   <= w_load_byte;
                        r_mosi <= w_load_byte[7];
                        r_bit  <= 3'd0;
                        r_div  <= DIV_LD;
                    end
                end
                ST_SHIFT: begin
                    if (!w_div_zero) begin
                        r_div <= r_div - 16'd1;
                    end else if (!r_sclk) begin
                        r_div  <= DIV_LD;
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[6:0], i_spi_miso};
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit == 3'd7) begin
                            // The header's receive byte is meaningless and is dropped.
                            if (!r_write && !r_header) begin
                                r_rd_data  <= r_rx;
                                r_rd_valid <= 1'b1;
                            end
                            r_header <= 1'b0;
                            if (r_left == 5'd0) begin
                                r_div  <= CS_LD;
                                r_mosi <= 1'b0;
                            end else begin
                                r_left <= r_left - 5'd1;
                                r_div  <= GAP_LD;
                            end
                        end else begin
                            r_div  <= DIV_LD;
                            r_bit  <= r_bit + 3'd1;
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_mosi <= r_tx[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_spi_ss   = r_ss;
    assign o_spi_clk  = r_sclk;
    assign o_spi_mosi = r_mosi;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: doc/dcmctrl_spi_master.md
Name: dcmctrl_spi_master

Overview:
- SPI initiator that drives the dcmctrl SPI register port from the host side, on an FPGA or a test harness.
- Converts a command (read/write, 7-bit start address, byte count) into one chip-select-framed burst.
- Burst format: a header byte {write, addr[6:0]}, then data bytes at auto-incrementing addresses.
- Write data arrives on a valid/ready stream; read data leaves as single-cycle strobes.

Parameters:
- CLK_DIV, 8: clk cycles per SCLK half-period. Legal minimum is 4, so the responder can load read data before the byte-final falling edge.
- GAP_CYCLES, 8: clk cycles with SCLK low between consecutive bytes of a burst.
- CS_SETUP, 4: clk cycles from spi_ss falling to the first SCLK activity, and from the last byte to spi_ss rising.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; the command is accepted on the cycle cmd_valid && cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  7  start register address
- cmd_len  in  5  number of data bytes, 0..31 (0 = header-only frame)
- wr_data  in  8  next write byte
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  one-cycle pulse when the current wr_data is captured for shifting
- rd_data  out  8  received read byte
- rd_valid  out  1  one-cycle pulse, no backpressure
- busy  out  1  high whenever the state is not IDLE
- spi_ss  out  1  chip select, active low
- spi_clk  out  1  SCLK, idle low
- spi_mosi  out  1  data to responder
- spi_miso  in  1  data from responder

Behaviour:
- Reset values (applied asynchronously): spi_ss=1, spi_clk=0, spi_mosi=0, rd_valid=0, wr_ready=0, rd_data=0, busy=0, state=IDLE, all counters 0. A reset mid-frame aborts immediately with no completion pulse.
- SPI mode 0, MSB first:
  - mosi changes only while SCLK is low.
  - miso is sampled on every rising SCLK edge (the responder updates it on falling edges).
- IDLE: cmd_ready=1.
  - On accept, latch write/addr/len and go to SETUP.
  - spi_ss goes low on the cycle after accept.
- SETUP: wait CS_SETUP cycles, then LOAD with header byte = {cmd_write, cmd_addr}.
- LOAD (data bytes):
  - Write burst: wait for wr_valid; meanwhile spi_ss stays low and SCLK stays low, with no timeout. Capture wr_data and pulse wr_ready on the capture cycle.
  - Read burst: load 0x00 immediately.
  - Then go to SHIFT.
- SHIFT, for each of 8 bits:
  - Drive the bit on mosi and hold SCLK low for CLK_DIV cycles.
  - Raise SCLK and shift miso into rx_shift; hold high for CLK_DIV cycles.
  - Lower SCLK.
  - A byte therefore lasts exactly 16*CLK_DIV cycles. The byte-final falling edge occurs CLK_DIV cycles after the 8th rising edge.
- After each byte:
  - Read burst, data bytes only: rd_data=rx_shift and rd_valid=1 for one cycle, on the cycle after the byte-final falling edge. The header byte's rx is discarded.
  - Decrement the remaining count. If bytes remain, go to GAP (GAP_CYCLES, SCLK low) then LOAD. Otherwise go to HOLD.
- HOLD: wait CS_SETUP cycles with SCLK low, then spi_ss=1 and go to IDLE. spi_mosi returns to 0.
- Addressing: auto-increment is the responder's job; the master never sends addresses after the header.
- cmd_len=0 frame: header only, then HOLD. No rd_valid and no wr_ready pulses occur.
- Frame length (no stalls), N = cmd_len: CS_SETUP + (N+1)*16*CLK_DIV + N*GAP_CYCLES + CS_SETUP cycles of spi_ss low, plus one cycle per LOAD.
- cmd_valid is ignored while busy. Commands are never queued.

Test Plan:
- Write, addr 0x05, len 3, data 0x11,0x22,0x33, against a responder model.
  - MOSI frame must be 0x85,0x11,0x22,0x33.
  - Model memory[5..7] must equal 0x11,0x22,0x33.
  - Exactly 3 wr_ready pulses; spi_ss is low for the whole frame.
- Read, addr 0x40, len 2, model mem[0x40]=0xA5, mem[0x41]=0x3C.
  - MOSI header must be 0x40.
  - rd_valid must pulse twice, with rd_data 0xA5 then 0x3C.
- Timing, CLK_DIV=4, GAP_CYCLES=8:
  - Every SCLK high and low phase must be exactly 4 cycles.
  - Inter-byte low time must be 4+8+1 cycles.
  - mosi must never change while SCLK is high.
- Stall: in a write len 2, deassert wr_valid for 50 cycles before the second data byte.
  - SCLK must stay 0 and spi_ss stay 0 during the stall.
  - The frame must resume with the correct byte.
- Reset asserted mid-bit of the header byte: on the same edge, with no clk required, spi_ss=1, spi_clk=0 and busy=0 must hold. cmd_ready must be 1 on the first clk after release.
- cmd_len=0, write, addr 0x7F: exactly one byte 0xFF is shifted, with no wr_ready and no rd_valid; busy drops at frame end.
